// File: rtl/onchip_mem_test_pkg.sv
// Shared types and pattern arithmetic for the on-chip RAM test engine.
// Build option: MEMTEST_LFSR_EN selects the Galois LFSR pattern instead of seed+i.
package onchip_mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FILL,
        RD_ISSUE,
        RD_DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;
    localparam int          DEF_MEM_DEPTH = 8216;
    localparam int          PAT_W         = 32;

    // Value loaded into a pattern generator when a run starts.
    function automatic logic [PAT_W-1:0] pattern_seed(input logic [PAT_W-1:0] s);
`ifdef MEMTEST_LFSR_EN
        // An all-zero LFSR state would lock up, so it is replaced by 1.
        pattern_seed = (s == '0) ? {{(PAT_W-1){1'b0}}, 1'b1} : s;
`else
        pattern_seed = s;
`endif
    endfunction

    function automatic logic [PAT_W-1:0] pattern_next(input logic [PAT_W-1:0] p);
`ifdef MEMTEST_LFSR_EN
        pattern_next = p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
`else
        pattern_next = p + 1'b1;
`endif
    endfunction

endpackage

// File: rtl/onchip_mem_test_pattern_gen.sv
// Pattern sequencer: loads a seed, advances one step per enable, presents P(i).
// Sequence type is chosen by MEMTEST_LFSR_EN through the package functions.
module onchip_mem_test_pattern_gen
    import onchip_mem_test_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] pattern
);

    logic [DATA_W-1:0] pattern_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_reg <= '0;
        end else if (load) begin
            pattern_reg <= DATA_W'(pattern_seed(PAT_W'(seed)));
        end else if (step) begin
            pattern_reg <= DATA_W'(pattern_next(PAT_W'(pattern_reg)));
        end
    end

    assign pattern = pattern_reg;

endmodule

// File: rtl/onchip_mem_test_engine.sv
// Avalon-MM fill/verify engine driving the s1 port of the single-port on-chip RAM.
// Build option: MEMTEST_LFSR_EN (LFSR data pattern, otherwise seed+i).
module onchip_mem_test_engine
    import onchip_mem_test_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                verify_en,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                range_err,
    output logic                mismatch,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    // Two spare bits so base + count can never wrap, whatever count is driven.
    localparam logic [ADDR_W+1:0] DEPTH_LIM  = (ADDR_W+2)'(MEM_DEPTH);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W:0]     count_reg;
    logic                verify_reg;
    logic [ADDR_W:0]     idx_reg;
    logic [1:0]          drain_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                range_err_reg;
    logic                mismatch_reg;
    logic [ADDR_W-1:0]   err_addr_reg;
    logic [ADDR_W:0]     err_count_reg;
    logic [ADDR_W-1:0]   mem_address_reg;
    logic [3:0]          mem_byteenable_reg;
    logic                mem_chipselect_reg;
    logic                mem_write_reg;

    logic                accept;
    logic                last_item;
    logic [ADDR_W+1:0]   end_addr;
    logic                rd_issue;
    logic [DATA_W-1:0]   wr_pattern;
    logic [DATA_W-1:0]   exp_pattern;
    logic                cmp_fail;

    logic                pipe_valid_reg [RD_LATENCY];
    logic [DATA_W-1:0]   pipe_exp_reg   [RD_LATENCY];
    logic [ADDR_W-1:0]   pipe_addr_reg  [RD_LATENCY];
    logic                pipe_valid_in  [RD_LATENCY];
    logic [DATA_W-1:0]   pipe_exp_in    [RD_LATENCY];
    logic [ADDR_W-1:0]   pipe_addr_in   [RD_LATENCY];

    assign accept    = (state_reg == IDLE) && start;
    assign last_item = ((idx_reg + 1'b1) == count_reg);
    assign end_addr  = {2'b00, base_reg} + {1'b0, count_reg};
    assign rd_issue  = mem_chipselect_reg && !mem_write_reg;

    onchip_mem_test_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_wr_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (state_reg == FILL),
        .seed    (seed),
        .pattern (wr_pattern)
    );

    // Expected-data copy advances only when a read is actually on the bus.
    onchip_mem_test_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_exp_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (rd_issue),
        .seed    (seed),
        .pattern (exp_pattern)
    );

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_valid_in[gi] = rd_issue;
                assign pipe_exp_in[gi]   = exp_pattern;
                assign pipe_addr_in[gi]  = mem_address_reg;
            end else begin : g_tail
                assign pipe_valid_in[gi] = pipe_valid_reg[gi-1];
                assign pipe_exp_in[gi]   = pipe_exp_reg[gi-1];
                assign pipe_addr_in[gi]  = pipe_addr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_valid_reg[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_valid_reg[k] <= pipe_valid_in[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < RD_LATENCY; k++) begin
            pipe_exp_reg[k]  <= pipe_exp_in[k];
            pipe_addr_reg[k] <= pipe_addr_in[k];
        end
    end

    // The last pipe stage lines up with mem_readdata for the read it tracks.
    assign cmp_fail = pipe_valid_reg[RD_LATENCY-1] &&
                      (mem_readdata != pipe_exp_reg[RD_LATENCY-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            base_reg           <= '0;
            count_reg          <= '0;
            verify_reg         <= 1'b0;
            idx_reg            <= '0;
            drain_reg          <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            range_err_reg      <= 1'b0;
            mismatch_reg       <= 1'b0;
            err_addr_reg       <= '0;
            err_count_reg      <= '0;
            mem_address_reg    <= '0;
            mem_byteenable_reg <= '0;
            mem_chipselect_reg <= 1'b0;
            mem_write_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (cmp_fail) begin
                if (err_count_reg != '1) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
                if (!mismatch_reg) begin
                    mismatch_reg <= 1'b1;
                    err_addr_reg <= pipe_addr_reg[RD_LATENCY-1];
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        count_reg     <= word_count;
                        verify_reg    <= verify_en;
                        busy_reg      <= 1'b1;
                        range_err_reg <= 1'b0;
                        mismatch_reg  <= 1'b0;
                        err_addr_reg  <= '0;
                        err_count_reg <= '0;
                        state_reg     <= CHECK;
                    end
                end
                CHECK: begin
                    if (count_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (end_addr > DEPTH_LIM) begin
                        range_err_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        mem_chipselect_reg <= 1'b1;
                        mem_write_reg      <= 1'b1;
                        mem_byteenable_reg <= 4'hF;
                        mem_address_reg    <= base_reg;
                        idx_reg            <= '0;
                        state_reg          <= FILL;
                    end
                end
                FILL: begin
                    if (last_item) begin
                        idx_reg       <= '0;
                        mem_write_reg <= 1'b0;
                        if (verify_reg) begin
                            mem_address_reg <= base_reg;
                            state_reg       <= RD_ISSUE;
                        end else begin
                            mem_chipselect_reg <= 1'b0;
                            mem_byteenable_reg <= '0;
                            done_reg           <= 1'b1;
                            state_reg          <= DONE;
                        end
                    end else begin
                        idx_reg         <= idx_reg + 1'b1;
                        mem_address_reg <= mem_address_reg + 1'b1;
                    end
                end
                RD_ISSUE: begin
                    if (last_item) begin
                        mem_chipselect_reg <= 1'b0;
                        mem_byteenable_reg <= '0;
                        drain_reg          <= '0;
                        state_reg          <= RD_DRAIN;
                    end else begin
                        idx_reg         <= idx_reg + 1'b1;
                        mem_address_reg <= mem_address_reg + 1'b1;
                    end
                end
                RD_DRAIN: begin
                    if (drain_reg == DRAIN_LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                DONE: begin
                    // busy stays up through the done cycle and falls with it.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign range_err      = range_err_reg;
    assign mismatch       = mismatch_reg;
    assign err_addr       = err_addr_reg;
    assign err_count      = err_count_reg;
    assign mem_address    = mem_address_reg;
    assign mem_byteenable = mem_byteenable_reg;
    assign mem_chipselect = mem_chipselect_reg;
    assign mem_write      = mem_write_reg;
    assign mem_writedata  = mem_write_reg ? wr_pattern : '0;
    assign mem_clken      = 1'b1;

endmodule
